// File: rtl/ballot_pkg.sv
// Shared types for the ballot entry front end: FSM states, candidate count and
// the one-hot selection test.
package ballot_pkg;

    localparam int N_CAND = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        SELECTED,
        CAST,
        LOCKED
    } state_t;

    // True only when exactly one candidate button is held.
    function automatic logic is_onehot4(input logic [N_CAND-1:0] v);
        logic [N_CAND-1:0] low;
        low = v - N_CAND'(1);
        return (v != '0) && ((v & low) == '0);
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a stability counter; the debounced level only
// flips after DB_CYCLES consecutive synchronised samples disagree with it.
module input_debouncer #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic changed
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;

    // Any sample that agrees with the current level restarts the run, so a
    // glitch shorter than DB_CYCLES can never reach the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            changed <= 1'b0;
        end else begin
            sync_a  <= raw;
            sync_b  <= sync_a;
            changed <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                level   <= sync_b;
                changed <= 1'b1;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ballot_entry_ctrl.sv
// Booth-side ballot entry: debounces officer arm, candidate and cast buttons and
// presents a stable one-hot selection with a fixed-length confirm to the counter.
module ballot_entry_ctrl
    import ballot_pkg::*;
#(
    parameter int DB_CYCLES   = 16,
    parameter int CONF_HOLD   = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm_i,
    input  logic [N_CAND-1:0] btn_i,
    input  logic              cast_i,
    output logic [N_CAND-1:0] voter_o,
    output logic              confirm_o,
    output logic              ready_o,
    output logic              cast_done_o,
    output logic              reject_o,
    output logic              timeout_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int HW = $clog2(CONF_HOLD + 1);

    logic              arm_r;
    logic              arm_chg;
    logic              cast_r;
    logic              cast_chg;
    logic [N_CAND-1:0] btn_r;
    logic [N_CAND-1:0] btn_chg;

    input_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_arm (
        .clk     (clk),
        .rst     (rst),
        .raw     (arm_i),
        .level   (arm_r),
        .changed (arm_chg)
    );

    input_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_cast (
        .clk     (clk),
        .rst     (rst),
        .raw     (cast_i),
        .level   (cast_r),
        .changed (cast_chg)
    );

    for (genvar k = 0; k < N_CAND; k++) begin : g_btn
        input_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_btn (
            .clk     (clk),
            .rst     (rst),
            .raw     (btn_i[k]),
            .level   (btn_r[k]),
            .changed (btn_chg[k])
        );
    end

    logic              arm_rise;
    logic              arm_fall;
    logic              cast_rise;
    logic [N_CAND-1:0] btn_rise;

    assign arm_rise  = arm_chg & arm_r;
    assign arm_fall  = arm_chg & ~arm_r;
    assign cast_rise = cast_chg & cast_r;
    assign btn_rise  = btn_chg & btn_r;

    state_t            state;
    state_t            state_nxt;
    logic [N_CAND-1:0] voter_nxt;
    logic [TW-1:0]     tmr;
    logic [TW-1:0]     tmr_nxt;
    logic [HW-1:0]     hold;
    logic [HW-1:0]     hold_nxt;
    logic              reject_nxt;
    logic              timeout_nxt;
    logic              done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            voter_o     <= '0;
            confirm_o   <= 1'b0;
            ready_o     <= 1'b0;
            cast_done_o <= 1'b0;
            reject_o    <= 1'b0;
            timeout_o   <= 1'b0;
            tmr         <= '0;
            hold        <= '0;
        end else begin
            state       <= state_nxt;
            voter_o     <= voter_nxt;
            confirm_o   <= (state_nxt == CAST);
            ready_o     <= (state_nxt == ARMED) || (state_nxt == SELECTED);
            cast_done_o <= done_nxt;
            reject_o    <= reject_nxt;
            timeout_o   <= timeout_nxt;
            tmr         <= tmr_nxt;
            hold        <= hold_nxt;
        end
    end

    // Precedence in an open ballot: arm drop, then cast (which freezes the old
    // selection even if a button edge lands on the same cycle), then timeout.
    always_comb begin
        state_nxt   = state;
        voter_nxt   = voter_o;
        tmr_nxt     = '0;
        hold_nxt    = '0;
        reject_nxt  = 1'b0;
        timeout_nxt = 1'b0;
        done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (arm_rise) begin
                    state_nxt = ARMED;
                end
            end

            ARMED, SELECTED: begin
                if (arm_fall) begin
                    state_nxt = IDLE;
                    voter_nxt = '0;
                end else if ((state == SELECTED) && cast_rise) begin
                    state_nxt = CAST;
                end else if ((tmr == TW'(TIMEOUT_CYC - 1)) && (btn_chg == '0)) begin
                    state_nxt   = LOCKED;
                    voter_nxt   = '0;
                    timeout_nxt = 1'b1;
                end else begin
                    if (btn_rise != '0) begin
                        if (is_onehot4(btn_r)) begin
                            voter_nxt = btn_r;
                            state_nxt = SELECTED;
                        end else begin
                            reject_nxt = 1'b1;
                        end
                    end
                    if ((state == ARMED) && cast_rise) begin
                        reject_nxt = 1'b1;
                    end
                    if ((state_nxt == state) && (btn_chg == '0)) begin
                        tmr_nxt = tmr + TW'(1);
                    end
                end
            end

            CAST: begin
                if (hold == HW'(CONF_HOLD - 1)) begin
                    state_nxt = LOCKED;
                    voter_nxt = '0;
                    done_nxt  = 1'b1;
                end else begin
                    hold_nxt = hold + HW'(1);
                end
            end

            LOCKED: begin
                voter_nxt = '0;
                if (!arm_r && !cast_r) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                voter_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ballot_entry_ctrl.sv
// Self-checking bench for ballot_entry_ctrl: directed ballot scenarios plus random
// button traffic, all compared cycle by cycle against a behavioural booth model.
module tb_ballot_entry_ctrl;

    localparam int DB   = 4;
    localparam int HOLD = 4;
    localparam int TO   = 64;

    localparam int M_IDLE   = 0;
    localparam int M_ARMED  = 1;
    localparam int M_SEL    = 2;
    localparam int M_CAST   = 3;
    localparam int M_LOCKED = 4;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       arm_i  = 1'b0;
    logic       cast_i = 1'b0;
    logic [3:0] btn_i  = 4'd0;
    logic [3:0] voter_o;
    logic       confirm_o;
    logic       ready_o;
    logic       cast_done_o;
    logic       reject_o;
    logic       timeout_o;

    int checks   = 0;
    int failures = 0;

    // Behavioural booth model: raw sample history per input, debounced levels,
    // and the ballot's phase with its visible outputs.
    bit         hist[6][DB+2];
    bit         m_lvl[6];
    bit         m_chg[6];
    int         m_st;
    int         m_idle;
    int         m_hold;
    logic [3:0] m_voter;
    bit         m_reject;
    bit         m_timeout;
    bit         m_done;

    int         conf_cycles;
    int         done_count;
    int         reject_count;
    int         timeout_count;
    int         sel_events;
    logic [3:0] voter_at_rise;
    logic [3:0] prev_voter;
    logic       prev_conf;

    always #5 clk = ~clk;

    ballot_entry_ctrl #(
        .DB_CYCLES   (DB),
        .CONF_HOLD   (HOLD),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arm_i       (arm_i),
        .btn_i       (btn_i),
        .cast_i      (cast_i),
        .voter_o     (voter_o),
        .confirm_o   (confirm_o),
        .ready_o     (ready_o),
        .cast_done_o (cast_done_o),
        .reject_o    (reject_o),
        .timeout_o   (timeout_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] expVec();
        return {m_voter, m_st == M_CAST, (m_st == M_ARMED) || (m_st == M_SEL),
                m_done, m_reject, m_timeout};
    endfunction

    task automatic modelStep(input bit r, input bit a, input bit c, input bit [3:0] b);
        bit       arm_lvl, cast_lvl, arm_rise, arm_fall, cast_rise;
        bit [3:0] btn_lvl;
        bit       btn_rise_any, btn_chg_any, all_diff;
        bit [5:0] rv;
        int       prev;

        if (r) begin
            m_st = M_IDLE; m_idle = 0; m_hold = 0; m_voter = 4'd0;
            m_reject = 0; m_timeout = 0; m_done = 0;
            for (int ch = 0; ch < 6; ch++) begin
                m_lvl[ch] = 0;
                m_chg[ch] = 0;
                for (int k = 0; k < DB + 2; k++) hist[ch][k] = 0;
            end
            return;
        end

        arm_lvl      = m_lvl[0];
        cast_lvl     = m_lvl[1];
        arm_rise     = m_chg[0] && m_lvl[0];
        arm_fall     = m_chg[0] && !m_lvl[0];
        cast_rise    = m_chg[1] && m_lvl[1];
        btn_lvl      = {m_lvl[5], m_lvl[4], m_lvl[3], m_lvl[2]};
        btn_rise_any = 0;
        btn_chg_any  = 0;
        for (int k = 2; k < 6; k++) begin
            if (m_chg[k]) btn_chg_any = 1;
            if (m_chg[k] && m_lvl[k]) btn_rise_any = 1;
        end

        m_reject = 0; m_timeout = 0; m_done = 0;
        case (m_st)
            M_IDLE: if (arm_rise) begin m_st = M_ARMED; m_idle = 0; end
            M_ARMED, M_SEL: begin
                if (arm_fall) begin
                    m_st = M_IDLE; m_voter = 4'd0; m_idle = 0;
                end else if (m_st == M_SEL && cast_rise) begin
                    m_st = M_CAST; m_hold = 1;
                end else if (m_idle == TO - 1 && !btn_chg_any) begin
                    m_st = M_LOCKED; m_voter = 4'd0; m_timeout = 1;
                end else begin
                    prev = m_st;
                    if (btn_rise_any) begin
                        if ($countones(btn_lvl) == 1) begin
                            m_voter = btn_lvl;
                            m_st    = M_SEL;
                        end else begin
                            m_reject = 1;
                        end
                    end
                    if (prev == M_ARMED && cast_rise) m_reject = 1;
                    if (m_st == prev && !btn_chg_any) m_idle++;
                    else m_idle = 0;
                end
            end
            M_CAST: begin
                if (m_hold == HOLD) begin
                    m_st = M_LOCKED; m_voter = 4'd0; m_done = 1;
                end else begin
                    m_hold++;
                end
            end
            M_LOCKED: if (!arm_lvl && !cast_lvl) m_st = M_IDLE;
            default: m_st = M_IDLE;
        endcase

        rv = {b, c, a};
        for (int ch = 0; ch < 6; ch++) begin
            for (int k = DB + 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
            hist[ch][0] = rv[ch];
            all_diff = 1;
            for (int k = 2; k < DB + 2; k++) if (hist[ch][k] == m_lvl[ch]) all_diff = 0;
            m_chg[ch] = all_diff;
            if (all_diff) m_lvl[ch] = !m_lvl[ch];
        end
    endtask

    task automatic clearStats();
        conf_cycles = 0; done_count = 0; reject_count = 0;
        timeout_count = 0; sel_events = 0;
        voter_at_rise = 4'd0;
    endtask

    task automatic applyStimulus(input bit r, input bit a, input bit c, input bit [3:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            rst = r; arm_i = a; cast_i = c; btn_i = b;
            @(posedge clk);
            modelStep(r, a, c, b);
            #1;
            checkOutput("outs", 32'({voter_o, confirm_o, ready_o, cast_done_o, reject_o, timeout_o}),
                        32'(expVec()));
            if (confirm_o && !prev_conf) voter_at_rise = voter_o;
            if (confirm_o) conf_cycles++;
            if (cast_done_o) done_count++;
            if (reject_o) reject_count++;
            if (timeout_o) timeout_count++;
            if (voter_o != 4'd0 && voter_o != prev_voter) sel_events++;
            prev_conf  = confirm_o;
            prev_voter = voter_o;
        end
    endtask

    initial begin
        int         waited;
        bit         a_lvl;
        bit         c_lvl;
        logic [3:0] b_val;
        int         pick;

        prev_conf  = 1'b0;
        prev_voter = 4'd0;
        clearStats();

        applyStimulus(1, 0, 0, 4'd0, 3);
        checkOutput("reset_outs", 32'({voter_o, confirm_o, ready_o, cast_done_o, reject_o, timeout_o}), 32'd0);

        // Clean ballot for candidate 2.
        applyStimulus(0, 1, 0, 4'b0000, 10);
        applyStimulus(0, 1, 0, 4'b0100, 10);
        applyStimulus(0, 1, 0, 4'b0000, 10);
        applyStimulus(0, 1, 1, 4'b0000, 10);
        applyStimulus(0, 1, 0, 4'b0000, 20);
        checkOutput("conf_len", 32'(conf_cycles), 32'd4);
        checkOutput("voter_at_confirm", 32'(voter_at_rise), 32'b0100);
        checkOutput("cast_done_count", 32'(done_count), 32'd1);
        checkOutput("voter_after_cast", 32'(voter_o), 32'd0);

        // Arm still high: a second ballot must be refused.
        clearStats();
        applyStimulus(0, 1, 0, 4'b0001, 10);
        applyStimulus(0, 1, 0, 4'b0000, 10);
        applyStimulus(0, 1, 1, 4'b0000, 10);
        applyStimulus(0, 1, 0, 4'b0000, 20);
        checkOutput("no_second_confirm", 32'(conf_cycles), 32'd0);

        // Re-arm, then a bouncing button 1 that settles.
        applyStimulus(0, 0, 0, 4'b0000, 12);
        clearStats();
        applyStimulus(0, 1, 0, 4'b0000, 10);
        applyStimulus(0, 1, 0, 4'b0010, 1);
        applyStimulus(0, 1, 0, 4'b0000, 2);
        applyStimulus(0, 1, 0, 4'b0010, 3);
        applyStimulus(0, 1, 0, 4'b0000, 1);
        applyStimulus(0, 1, 0, 4'b0010, 2);
        applyStimulus(0, 1, 0, 4'b0000, 1);
        applyStimulus(0, 1, 0, 4'b0010, 12);
        checkOutput("bounce_voter", 32'(voter_o), 32'b0010);
        applyStimulus(0, 1, 0, 4'b0000, 6);
        applyStimulus(0, 1, 1, 4'b0000, 10);
        applyStimulus(0, 1, 0, 4'b0000, 20);
        checkOutput("bounce_sel_events", 32'(sel_events), 32'd1);
        checkOutput("rearm_conf_len", 32'(conf_cycles), 32'd4);
        checkOutput("rearm_voter_at_confirm", 32'(voter_at_rise), 32'b0010);

        // Multi-press and cast with nothing selected are both rejected.
        applyStimulus(0, 0, 0, 4'b0000, 12);
        applyStimulus(0, 1, 0, 4'b0000, 10);
        clearStats();
        applyStimulus(0, 1, 0, 4'b0011, 10);
        checkOutput("multi_voter", 32'(voter_o), 32'd0);
        applyStimulus(0, 1, 0, 4'b0000, 10);
        applyStimulus(0, 1, 1, 4'b0000, 10);
        applyStimulus(0, 1, 0, 4'b0000, 10);
        checkOutput("reject_count", 32'(reject_count), 32'd2);
        checkOutput("still_ready", 32'(ready_o), 32'd1);

        // Idle ballot is abandoned.
        applyStimulus(0, 0, 0, 4'b0000, 12);
        clearStats();
        applyStimulus(0, 1, 0, 4'b0000, 90);
        checkOutput("timeout_count", 32'(timeout_count), 32'd1);
        checkOutput("timeout_no_confirm", 32'(conf_cycles), 32'd0);
        checkOutput("timeout_ready", 32'(ready_o), 32'd0);

        // Reset lands on the second cycle of the confirm.
        applyStimulus(0, 0, 0, 4'b0000, 12);
        applyStimulus(0, 1, 0, 4'b0000, 10);
        applyStimulus(0, 1, 0, 4'b1000, 10);
        applyStimulus(0, 1, 0, 4'b0000, 10);
        waited = 0;
        while (!confirm_o && waited < 40) begin
            applyStimulus(0, 1, 1, 4'b0000, 1);
            waited++;
        end
        checkOutput("cast_wait", 32'(confirm_o), 32'd1);
        applyStimulus(0, 1, 1, 4'b0000, 1);
        applyStimulus(1, 1, 1, 4'b0000, 1);
        checkOutput("rst_cast_confirm", 32'(confirm_o), 32'd0);
        checkOutput("rst_cast_voter", 32'(voter_o), 32'd0);
        checkOutput("rst_cast_ready", 32'(ready_o), 32'd0);

        // Random traffic: slow arm changes, biased towards single presses.
        a_lvl = 1;
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 99) < 15) a_lvl = !a_lvl;
            c_lvl = ($urandom_range(0, 99) < 25);
            pick  = $urandom_range(0, 99);
            if (pick < 40)      b_val = 4'd0;
            else if (pick < 85) b_val = 4'b0001 << $urandom_range(0, 3);
            else                b_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 1) applyStimulus(1, a_lvl, c_lvl, b_val, 1);
            applyStimulus(0, a_lvl, c_lvl, b_val, $urandom_range(1, 12));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
